// File: rtl/eth_crc_pkg.sv
// Shared CRC-32 constants, per-byte update function and frame-length limits
// for the Ethernet CRC stream engine.
package eth_crc_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam int unsigned RUNT_LIMIT  = 64;
  localparam int unsigned GIANT_LIMIT = 1522;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } crc_state_t;

  // Reflected CRC-32 over one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] state, input logic [7:0] data);
    logic [31:0] c;
    c = state ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_step.sv
// Combinational CRC-32 advance over DW bytes; nbytes selects how many leading
// bytes count (0 or >DW means all DW).
module eth_crc32_step
  import eth_crc_pkg::*;
#(
  parameter int DW  = 4,
  parameter int NBW = $clog2(DW) + 1
) (
  input  logic [31:0]     crc_in,
  input  logic [8*DW-1:0] data,
  input  logic [NBW-1:0]  nbytes,
  output logic [31:0]     crc_out
);

  logic [31:0] chain [DW+1];

  always_comb begin
    chain[0] = crc_in;
    for (int i = 0; i < DW; i++) begin
      chain[i+1] = crc32_byte(chain[i], data[8*i +: 8]);
    end
    crc_out = chain[DW];
    for (int i = 1; i < DW; i++) begin
      if (nbytes == NBW'(i)) crc_out = chain[i];
    end
  end

endmodule

// File: rtl/eth_crc32_stream.sv
// Multi-byte-per-beat Ethernet CRC-32 stream engine with one-entry result slot.
// Optional frame length/runt/giant outputs under ETH_CRC32_STREAM_LEN_EN.
//
// state   | meaning
// IDLE    | no frame in progress; next accepted beat starts a frame
// BUSY    | frame in progress; a last beat returns to IDLE
module eth_crc32_stream
  import eth_crc_pkg::*;
#(
  parameter int DW = 4,
  localparam int NBW = $clog2(DW) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*DW-1:0] in_data,
  input  logic            in_last,
  input  logic [NBW-1:0]  in_nbytes,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_fcs,
  output logic            res_good
`ifdef ETH_CRC32_STREAM_LEN_EN
  ,
  output logic [15:0]     res_len,
  output logic            res_runt,
  output logic            res_giant
`endif
);

  crc_state_t  st_q, st_d;
  logic [31:0] crc_q, crc_nxt;
  logic [NBW-1:0] step_nbytes;
  logic        accept;

  assign in_ready    = ~res_valid | res_ready;
  assign accept      = in_valid & in_ready;
  assign step_nbytes = in_last ? in_nbytes : NBW'(DW);

  eth_crc32_step #(.DW(DW), .NBW(NBW)) u_step (
    .crc_in  (crc_q),
    .data    (in_data),
    .nbytes  (step_nbytes),
    .crc_out (crc_nxt)
  );

  always_comb begin
    st_d = st_q;
    if (accept) st_d = in_last ? ST_IDLE : ST_BUSY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      crc_q     <= CRC32_INIT;
      res_valid <= 1'b0;
      res_fcs   <= 32'h0;
      res_good  <= 1'b0;
    end else begin
      st_q <= st_d;
      if (res_ready) res_valid <= 1'b0;
      if (accept) begin
        if (in_last) begin
          // Result load wins over a same-cycle consume, so res_valid stays high.
          crc_q     <= CRC32_INIT;
          res_valid <= 1'b1;
          res_fcs   <= ~crc_nxt;
          res_good  <= (crc_nxt == CRC32_RESIDUE);
        end else begin
          crc_q <= crc_nxt;
        end
      end
    end
  end

`ifdef ETH_CRC32_STREAM_LEN_EN
  logic [15:0] len_q, len_base, beat_bytes, len_sat;
  logic [16:0] len_sum;

  always_comb begin
    beat_bytes = 16'(DW);
    if (in_last && (in_nbytes != '0) && (int'(in_nbytes) <= DW)) beat_bytes = 16'(in_nbytes);
    len_base = (st_q == ST_BUSY) ? len_q : 16'h0;
    len_sum  = {1'b0, len_base} + {1'b0, beat_bytes};
    len_sat  = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= 16'h0;
      res_len   <= 16'h0;
      res_runt  <= 1'b0;
      res_giant <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        len_q     <= 16'h0;
        res_len   <= len_sat;
        res_runt  <= (len_sat < 16'(RUNT_LIMIT));
        res_giant <= (len_sat > 16'(GIANT_LIMIT));
      end else begin
        len_q <= len_sat;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_crc32_stream.sv
// Directed bench for eth_crc32_stream (DW=4) with a result scoreboard;
// length outputs are checked when ETH_CRC32_STREAM_LEN_EN is defined.
module tb_eth_crc32_stream;

  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [8*DW-1:0] in_data = '0;
  logic            in_last = 1'b0;
  logic [2:0]      in_nbytes = 3'd0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [31:0]     res_fcs;
  logic            res_good;
`ifdef ETH_CRC32_STREAM_LEN_EN
  logic [15:0]     res_len;
  logic            res_runt;
  logic            res_giant;
`endif

  eth_crc32_stream #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_fcs   (res_fcs),
    .res_good  (res_good)
`ifdef ETH_CRC32_STREAM_LEN_EN
    ,
    .res_len   (res_len),
    .res_runt  (res_runt),
    .res_giant (res_giant)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fcs;
    logic        good;
    int          len;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  frm[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [7:0]  vec [16] = '{8'h6e, 8'hb9, 8'h34, 8'h70, 8'h3b, 8'h77, 8'hc7, 8'hae,
                            8'h29, 8'h52, 8'h14, 8'h3e, 8'h09, 8'ha6, 8'h94, 8'h60};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Bit-serial reference CRC over frm[].
  function automatic logic [31:0] model_crc();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (frm[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ frm[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic load_vec(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(vec[i]);
  endtask

  task automatic load_rand(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
  endtask

  // Drive one beat at #1 after an edge and wait until it is accepted.
  task automatic drive_beat(input logic [8*DW-1:0] d, input logic last, input logic [2:0] nb);
    int guard;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_nbytes = nb;
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  // Send frm[] as one frame; nb_force overrides in_nbytes on the last beat when >= 0.
  task automatic send_frame(input logic [31:0] exp_fcs, input logic exp_good, input int nb_force);
    int n, nbeats, rem;
    logic [8*DW-1:0] d;
    exp_t e;
    n = frm.size();
    nbeats = (n + DW - 1) / DW;
    e.fcs = exp_fcs; e.good = exp_good; e.len = n;
    for (int b = 0; b < nbeats; b++) begin
      d = '0;
      rem = n - b*DW;
      for (int k = 0; k < DW; k++) if (k < rem) d[8*k +: 8] = frm[b*DW + k];
      if (b == nbeats - 1) begin
        sb.push_back(e);
        drive_beat(d, 1'b1, (nb_force >= 0) ? 3'(nb_force) : 3'(rem));
        chk("latency_res_valid", 32'(res_valid), 32'd1);
      end else begin
        drive_beat(d, 1'b0, 3'd0);
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(res_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_fcs", res_fcs, e.fcs);
        chk("res_good", 32'(res_good), 32'(e.good));
`ifdef ETH_CRC32_STREAM_LEN_EN
        chk("res_len", 32'(res_len), 32'(e.len));
        chk("res_runt", 32'(res_runt), 32'(e.len < 64));
        chk("res_giant", 32'(res_giant), 32'(e.len > 1522));
`endif
      end
    end
  end

  initial begin
    exp_t ea, eb;
    logic [8*DW-1:0] d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_fcs", res_fcs, 32'h0);
    chk("rst_res_good", 32'(res_good), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer frames, then partial last beats; these run back to back.
    load_vec(12); send_frame(32'h6094A609, 1'b0, -1);
    load_vec(16); send_frame(32'h2144DF1C, 1'b1, -1);
    load_vec(13); send_frame(~model_crc(), model_crc() == 32'hDEBB20E3, -1);
    load_vec(14); send_frame(~model_crc(), 1'b0, -1);
    load_vec(15); send_frame(~model_crc(), 1'b0, -1);
    load_vec(16); send_frame(32'h2144DF1C, 1'b1, 0);
    load_vec(1);  send_frame(~model_crc(), 1'b0, -1);
    load_vec(3);  send_frame(~model_crc(), 1'b0, -1);
    idle();
    repeat (2) @(posedge clk); #1;

    // Result held while res_ready=0; second frame waits, then lands with no loss.
    res_ready = 1'b0;
    load_rand(4); send_frame(~model_crc(), 1'b0, -1);
    ea = sb[0];
    load_rand(2);
    eb.fcs = ~model_crc(); eb.good = 1'b0; eb.len = 2;
    sb.push_back(eb);
    d = '0; d[15:0] = {frm[1], frm[0]};
    in_valid = 1'b1; in_data = d; in_last = 1'b1; in_nbytes = 3'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_res_fcs", res_fcs, ea.fcs);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    idle();
    chk("replace_res_valid", 32'(res_valid), 32'd1);
    repeat (2) @(posedge clk); #1;

    // Reset in mid-frame: aborted frame must not produce a result.
    load_vec(8);
    drive_beat({frm[3], frm[2], frm[1], frm[0]}, 1'b0, 3'd0);
    drive_beat({frm[7], frm[6], frm[5], frm[4]}, 1'b0, 3'd0);
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);
    load_vec(16); send_frame(32'h2144DF1C, 1'b1, -1);
    idle();

    // Length boundary frames (content random, CRC from model).
    load_rand(60);   send_frame(~model_crc(), 1'b0, -1);
    load_rand(1523); send_frame(~model_crc(), 1'b0, -1);
    load_rand(64);   send_frame(~model_crc(), 1'b0, -1);
    load_rand(65);   send_frame(~model_crc(), 1'b0, -1);
    idle();

    repeat (4) @(posedge clk); #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/eth_crc32_stream.md
Name: eth_crc32_stream

Overview:
Parametrised, multi-byte-per-beat successor to the single-byte Ethernet CRC-32 engine. It consumes a valid/ready frame stream of DW bytes per beat, with a partial last beat allowed. At each frame end it emits, through a one-entry result handshake, the computed FCS and a residue-check verdict. It sits between the MAC byte stream and the RX/TX framers, covering both FCS generation (TX) and FCS checking (RX).

Parameters:
DW, 4, data bytes per beat; legal values 1, 2, 4, 8.
NBW, $clog2(DW)+1, width of in_nbytes (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
in_data  in  8*DW  beat data; byte 0 = bits [7:0], processed first
in_last  in  1  final beat of frame
in_nbytes  in  NBW  valid byte count on last beat, 1..DW; ignored when in_last=0
res_valid  out  1  frame result available
res_ready  in  1  result consumed when res_valid & res_ready
res_fcs  out  32  FCS = ~crc state over all frame bytes; transmitted LSB byte first
res_good  out  1  crc state after final byte == 32'hDEBB20E3 (frame includes its FCS)

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high on clk.
  - Reset values: crc state 32'hFFFFFFFF, res_valid=0, res_fcs=0, res_good=0.
  - Reset mid-frame discards the partial frame and any pending result.
- CRC definition: reflected polynomial 32'hEDB88320, init 32'hFFFFFFFF, LSB-first bit order within each byte.
- Per accepted beat: the state advances over the valid bytes in order.
  - Non-last beat: all DW bytes are valid.
  - Last beat: in_nbytes bytes (0..nbytes-1) are valid. in_nbytes==0 or >DW is illegal and is treated as DW.
- Input handshake:
  - in_ready = ~res_valid | res_ready, combinational from res_valid/res_ready only; in_ready does not depend on in_valid.
  - in_data, in_last and in_nbytes are held by the source while in_valid & ~in_ready.
- Accepting the last beat:
  - On the next clk edge, res_valid goes to 1, res_fcs and res_good are loaded, and the state returns to 32'hFFFFFFFF.
  - Latency from the last beat accepted to res_valid is 1 cycle.
  - A new frame may start on the very next cycle (back-to-back frames, no bubble).
- Result handshake:
  - res_valid holds, and res_fcs/res_good stay stable, until res_ready.
  - If a result is consumed and a new last beat is accepted in the same cycle, the new result replaces the old one next cycle and res_valid stays 1.
- State machine (2 states):
  - IDLE: no frame in progress. Any accepted beat goes to BUSY, or stays in IDLE if that beat is also the last.
  - BUSY: a last beat returns to IDLE.
  - The state is visible only through the optional counter; CRC behaviour is identical in both states.
- Single-beat frames (in_last on the first beat) are legal, including a 1-byte frame.
- Zero-length frames cannot be expressed.

Optional Feature:
Macro ETH_CRC32_STREAM_LEN_EN.
- Defined:
  - Adds output res_len (16 bits): byte count of the frame, latched with res_fcs.
  - Adds output res_runt (1 bit): res_len < 64.
  - Adds output res_giant (1 bit): res_len > 1522.
  - The internal counter saturates at 16'hFFFF, resets to 0 at reset and at each frame end, and is reset by rst.
- Undefined: no counter logic and the three ports are absent; all other behaviour is identical.

Decomposition:
- Package eth_crc_pkg:
  - Constants CRC32_POLY, CRC32_INIT, CRC32_RESIDUE.
  - Function crc32_byte(state, byte) returning the next state.
  - Localparams for the runt/giant limits (64, 1522).
- Sub-module eth_crc32_step (combinational):
  - Inputs: state, DW bytes, nbytes.
  - Output: next state, computed as a chained crc32_byte with a per-byte mux that selects the intermediate state after byte nbytes-1.
- The top level holds the registers, the IDLE/BUSY FSM, the handshake and the optional counter.

Test Plan:
- DW=1, bytes 6e b9 34 70 3b 77 c7 ae 29 52 14 3e, last on 3e -> res_fcs=32'h6094A609, res_good=0.
- DW=1, the same 12 bytes followed by 09 a6 94 60 -> res_good=1, res_fcs=~32'hDEBB20E3=32'h2144DF1C.
- DW=4, the same 16 bytes as 4 beats, then DW=8 as 2 beats -> identical res_fcs/res_good. Also DW=4 with 13 bytes, last beat nbytes=1 -> result matches the DW=1 run over the same 13 bytes.
- Back-to-back single-beat frames with res_ready held at 0 for 5 cycles -> in_ready=0 while res_valid=1. The first result is stable until consumed; the second is accepted in the release cycle and appears next cycle with no loss.
- Reset asserted mid-frame after 6 bytes, then the 16-byte good frame is sent -> res_good=1, and no result is produced for the aborted frame.
- LEN_EN defined: 60-byte frame -> res_len=60, res_runt=1; 1523-byte frame -> res_giant=1; 64-byte frame -> both flags 0.
